// File: rtl/integration_pkg.sv
// Shared widths and FSM encoding for the quadratic trapezoid-integration sequencer.
package integration_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_X_W    = 16;
  localparam int DEF_ACC_W  = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL1,
    MUL2,
    ACC,
    DONE
  } state_t;
endpackage

// File: rtl/integration_mul.sv
// Shared Horner multiplier: ACC_W operand times sign-extended x, truncated to ACC_W.
module integration_mul
  import integration_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int X_W   = DEF_X_W
) (
  input  logic [ACC_W-1:0] op,
  input  logic [X_W-1:0]   x,
  output logic [ACC_W-1:0] prod
);
  logic [ACC_W-1:0] x_ext;

  // The low ACC_W bits of a product are the same for signed and unsigned operands.
  assign x_ext = ACC_W'($signed(x));
  assign prod  = op * x_ext;
endmodule

// File: rtl/integration_sequencer.sv
// Evaluates a*x^2+b*x+c over integer x in [lo,hi] by Horner and accumulates 2*trapezoid area.
module integration_sequencer
  import integration_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int X_W    = DEF_X_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              s00_axi_aclk,
  input  logic              s00_axi_aresetn,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [X_W-1:0]    lo,
  input  logic [X_W-1:0]    hi,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ACC_W-1:0]  ans
);
  state_t                   state_reg;
  logic signed [DATA_W-1:0] a_reg;
  logic signed [DATA_W-1:0] b_reg;
  logic signed [DATA_W-1:0] c_reg;
  logic signed [X_W-1:0]    lo_reg;
  logic signed [X_W-1:0]    hi_reg;
  logic signed [X_W-1:0]    x_reg;
  logic [ACC_W-1:0]         t_reg;
  logic [ACC_W-1:0]         acc_reg;
  logic                     err_pend_reg;

  logic [ACC_W-1:0] mul_op;
  logic [ACC_W-1:0] mul_prod;
  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] weighted;
  logic             end_point;
  logic             running;

  assign mul_op    = (state_reg == MUL1) ? ACC_W'(a_reg) : t_reg + ACC_W'(b_reg);
  assign term      = t_reg + ACC_W'(c_reg);
  assign end_point = (x_reg == lo_reg) || (x_reg == hi_reg);
  // Interior samples are shared by two trapezoids, so they count twice.
  assign weighted  = end_point ? term : {term[ACC_W-2:0], 1'b0};
  assign running   = state_reg inside {LOAD, MUL1, MUL2, ACC};

  integration_mul #(
    .ACC_W(ACC_W),
    .X_W  (X_W)
  ) u_mul (
    .op  (mul_op),
    .x   (x_reg),
    .prod(mul_prod)
  );

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      c_reg        <= '0;
      lo_reg       <= '0;
      hi_reg       <= '0;
      x_reg        <= '0;
      t_reg        <= '0;
      acc_reg      <= '0;
      err_pend_reg <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      ans          <= '0;
    end else begin
      done <= 1'b0;
      if (abort && running) begin
        state_reg <= IDLE;
        busy      <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              a_reg     <= a;
              b_reg     <= b;
              c_reg     <= c;
              lo_reg    <= lo;
              hi_reg    <= hi;
              state_reg <= LOAD;
            end
          end
          LOAD: begin
            busy    <= 1'b1;
            x_reg   <= lo_reg;
            acc_reg <= '0;
            if (hi_reg <= lo_reg) begin
              err_pend_reg <= (hi_reg < lo_reg);
              state_reg    <= DONE;
            end else begin
              err_pend_reg <= 1'b0;
              state_reg    <= MUL1;
            end
          end
          MUL1: begin
            t_reg     <= mul_prod;
            state_reg <= MUL2;
          end
          MUL2: begin
            t_reg     <= mul_prod;
            state_reg <= ACC;
          end
          ACC: begin
            acc_reg <= acc_reg + weighted;
            if (x_reg == hi_reg) begin
              state_reg <= DONE;
            end else begin
              x_reg     <= x_reg + X_W'(1);
              state_reg <= MUL1;
            end
          end
          DONE: begin
            busy      <= 1'b0;
            done      <= 1'b1;
            ans       <= acc_reg;
            err       <= err_pend_reg;
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_integration_sequencer.sv
// Directed, table-driven bench for integration_sequencer with multi-cycle corner sequences.
module tb_integration_sequencer;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] a, b, c;
  logic [15:0] lo, hi;
  logic        busy, done, err;
  logic [63:0] ans;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [15:0] lo;
    logic [15:0] hi;
    longint      exp_ans;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  integration_sequencer dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(rst_n),
    .start          (start),
    .abort          (abort),
    .a              (a),
    .b              (b),
    .c              (c),
    .lo             (lo),
    .hi             (hi),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .ans            (ans)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string what, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", what, act, exp);
    end
  endtask

  function automatic longint model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic [31:0] mc, input logic [15:0] mlo,
                                   input logic [15:0] mhi);
    longint s, f, x, la, lb, lc;
    int     loi, hii;
    la  = longint'($signed(ma));
    lb  = longint'($signed(mb));
    lc  = longint'($signed(mc));
    loi = int'($signed(mlo));
    hii = int'($signed(mhi));
    s   = 0;
    if (hii <= loi) return 0;
    for (int i = loi; i <= hii; i++) begin
      x = longint'(i);
      f = la * x * x + lb * x + lc;
      s = s + (((i == loi) || (i == hii)) ? f : 2 * f);
    end
    return s;
  endfunction

  task automatic run_job(input vec_t v, input bit noise, input bit abort_first);
    int          lat;
    int          busy_bad;
    logic [63:0] got_ans;
    logic        got_err;
    a = v.a; b = v.b; c = v.c; lo = v.lo; hi = v.hi;
    start = 1'b1;
    abort = abort_first;
    tick();
    start = 1'b0;
    abort = 1'b0;
    lat = -1; busy_bad = 0; got_ans = '0; got_err = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      tick();
      if (busy !== (cyc < v.exp_lat)) busy_bad++;
      if (done === 1'b1) begin
        lat = cyc; got_ans = ans; got_err = err;
        break;
      end
      start = noise && (cyc >= 2) && (cyc <= 4);
      if (noise) begin
        a  = 32'd7;
        lo = 16'hFFF0;
      end
    end
    start = 1'b0;
    $display("job %s: latency=%0d ans=%0d err=%0d", v.name, lat, $signed(got_ans), got_err);
    check({v.name, " latency"}, longint'(lat), longint'(v.exp_lat));
    check({v.name, " ans"}, longint'(got_ans), v.exp_ans);
    check({v.name, " err"}, longint'(got_err), longint'(v.exp_err));
    check({v.name, " busy_profile_errors"}, longint'(busy_bad), 0);
    tick();
    check({v.name, " done_pulse_width"}, longint'(done), 0);
    check({v.name, " ans_held"}, longint'(ans), v.exp_ans);
  endtask

  initial begin
    vec_t xv;
    int   done_seen;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    a = '0; b = '0; c = '0; lo = '0; hi = '0;

    vecs[0] = '{"t1_square",     32'd1,        32'd0, 32'd0,        16'd0,    16'd2,    6,  1'b0, 11};
    vecs[1] = '{"t2_mixed",      32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 16'hFFFF, 16'd1,    -8, 1'b0, 11};
    vecs[2] = '{"t3_const",      32'd0,        32'd0, 32'd5,        16'hFFFD, 16'd3,    60, 1'b0, 23};
    vecs[3] = '{"t4_reversed",   32'd1,        32'd1, 32'd1,        16'd4,    16'd2,    0,  1'b1, 2};
    vecs[4] = '{"t4_single",     32'd1,        32'd1, 32'd1,        16'd7,    16'd7,    0,  1'b0, 2};
    vecs[5] = '{"ramp",          32'd0,        32'd1, 32'd0,        16'hFFFE, 16'd3,    5,  1'b0, 20};

    #12;
    check("reset busy", longint'(busy), 0);
    check("reset done", longint'(done), 0);
    check("reset err", longint'(err), 0);
    check("reset ans", longint'(ans), 0);
    #1 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_job(vecs[i], 1'b0, 1'b0);

    // Start pulses and operand changes during a run must be ignored.
    xv = '{"busy_noise", 32'd1, 32'd0, 32'd0, 16'd0, 16'd3, 19, 1'b0, 14};
    run_job(xv, 1'b1, 1'b0);

    // Abort in MUL2 of the second point: state after accept edge k+5 is MUL2(p2).
    a = 32'd2; b = '0; c = '0; lo = 16'd0; hi = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("abort pre busy", longint'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort busy", longint'(busy), 0);
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    $display("job abort: done_seen=%0d ans=%0d err=%0d", done_seen, $signed(ans), err);
    check("abort no_done", longint'(done_seen), 0);
    check("abort ans_kept", longint'(ans), 19);
    check("abort err_kept", longint'(err), 0);
    check("abort busy_idle", longint'(busy), 0);

    // Start together with abort in IDLE: start wins and the job completes.
    xv = '{"start_abort", 32'd2, 32'd0, 32'd0, 16'd0, 16'd3, 38, 1'b0, 14};
    run_job(xv, 1'b0, 1'b1);

    // Asynchronous reset in the middle of an ACC cycle.
    a = 32'd1; b = '0; c = '0; lo = 16'd0; hi = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("midreset pre busy", longint'(busy), 1);
    #3 rst_n = 1'b0;
    #1;
    $display("job midreset: busy=%0d done=%0d err=%0d ans=%0d", busy, done, err, $signed(ans));
    check("midreset busy", longint'(busy), 0);
    check("midreset done", longint'(done), 0);
    check("midreset err", longint'(err), 0);
    check("midreset ans", longint'(ans), 0);
    #2 rst_n = 1'b1;
    tick();
    check("midreset idle busy", longint'(busy), 0);

    xv = '{"wrap_low", 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 16'h8000, 16'h8008, 0, 1'b0, 29};
    xv.exp_ans = model(xv.a, xv.b, xv.c, xv.lo, xv.hi);
    run_job(xv, 1'b0, 1'b0);

    xv = '{"wrap_high", 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 16'h7FF7, 16'h7FFF, 0, 1'b0, 29};
    xv.exp_ans = model(xv.a, xv.b, xv.c, xv.lo, xv.hi);
    run_job(xv, 1'b0, 1'b0);

    xv = '{"wrap_span", 32'h7FFFFFFF, 32'h00001234, 32'h80000000, 16'h8000, 16'h7FFF, 0, 1'b0, 2};
    xv.lo = 16'h7FFF; xv.hi = 16'h8000; xv.exp_err = 1'b1;
    xv.exp_ans = model(xv.a, xv.b, xv.c, xv.lo, xv.hi);
    run_job(xv, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
